// File: rtl/draw_pkg.sv
// Shared definitions for the frame draw scheduler and the game controller:
// scheduler FSM states and the fixed shape ID map.
package draw_pkg;

  localparam int NUM_SHAPES_DEF = 18;
  localparam int SHAPE_ID_W     = $clog2(NUM_SHAPES_DEF);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_START        = 3'd1,
    ST_WAIT_DONE    = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_NEXT         = 3'd4
  } sched_state_e;

  localparam int ID_SQUARE_FIRST = 0;
  localparam int ID_SQUARE_LAST  = 6;
  localparam int ID_BLOCK_FIRST  = 7;
  localparam int ID_BLOCK_LAST   = 11;
  localparam int ID_SPIKE_FIRST  = 12;
  localparam int ID_SPIKE_LAST   = 16;
  localparam int ID_CLEAR        = 17;

endpackage

// File: rtl/draw_scheduler_shape_port_mux.sv
// shape_port_mux: selects one shape's pixel stream onto the shared VGA port.
// Plot is gated by i_plot_en so idle/handoff cycles never write pixels.
module shape_port_mux #(
  parameter int NUM_SHAPES = 18,
  parameter int COORD_W    = 11,
  parameter int COLOUR_W   = 3,
  parameter int ID_W       = 5
) (
  input  logic [ID_W-1:0]                i_sel,
  input  logic                           i_plot_en,
  input  logic [NUM_SHAPES-1:0]          i_plot,
  input  logic [NUM_SHAPES*COORD_W-1:0]  i_x,
  input  logic [NUM_SHAPES*COORD_W-1:0]  i_y,
  input  logic [NUM_SHAPES*COLOUR_W-1:0] i_colour,
  output logic [COORD_W-1:0]             o_x,
  output logic [COORD_W-1:0]             o_y,
  output logic [COLOUR_W-1:0]            o_colour,
  output logic                           o_plot
);

  // Slice selection by shape ID; out-of-range IDs yield a silent port.
  always_comb begin
    o_x      = '0;
    o_y      = '0;
    o_colour = '0;
    o_plot   = 1'b0;
    if (int'(i_sel) < NUM_SHAPES) begin
      o_x      = i_x[int'(i_sel)*COORD_W +: COORD_W];
      o_y      = i_y[int'(i_sel)*COORD_W +: COORD_W];
      o_colour = i_colour[int'(i_sel)*COLOUR_W +: COLOUR_W];
      o_plot   = i_plot[i_sel] & i_plot_en;
    end else begin
      o_plot   = 1'b0;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame sequencing of shape engines onto the VGA port.
// Optional per-shape watchdog enabled by defining DRAW_SCHEDULER_TIMEOUT_EN.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int NUM_SHAPES     = 18,
  parameter int CLEAR_ID       = ID_CLEAR,
  parameter int COORD_W        = 11,
  parameter int COLOUR_W       = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               frame_tick,
  input  logic [NUM_SHAPES-1:0]              shape_enable,
  input  logic [NUM_SHAPES-1:0]              draw_done,
  input  logic [NUM_SHAPES-1:0]              load_plot,
  input  logic [NUM_SHAPES*COORD_W-1:0]      load_x,
  input  logic [NUM_SHAPES*COORD_W-1:0]      load_y,
  input  logic [NUM_SHAPES*COLOUR_W-1:0]     load_colour,
  output logic [NUM_SHAPES-1:0]              draw_start,
  output logic [COORD_W-1:0]                 vga_x,
  output logic [COORD_W-1:0]                 vga_y,
  output logic [COLOUR_W-1:0]                vga_colour,
  output logic                               vga_plot,
  output logic [$clog2(NUM_SHAPES)-1:0]      curr_shape_id,
  output logic                               frame_busy,
`ifdef DRAW_SCHEDULER_TIMEOUT_EN
  output logic                               shape_timeout,
`endif
  output logic                               frame_overrun
);

  localparam int ID_W = $clog2(NUM_SHAPES);
  localparam logic [ID_W-1:0] CLEAR_SEL = ID_W'(CLEAR_ID);

  sched_state_e          r_state, w_state_nxt;
  logic [NUM_SHAPES-1:0] r_mask, r_draw_start;
  logic [ID_W-1:0]       r_curr_id, w_next_id;
  logic                  r_busy, r_overrun;
  logic                  w_next_found, w_done_cur, w_wdog_hit, w_plot_en;

  assign w_done_cur = draw_done[r_curr_id];
  assign w_plot_en  = (r_state == ST_START) || (r_state == ST_WAIT_DONE);

`ifdef DRAW_SCHEDULER_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_timeout;

  assign w_wdog_hit = ((r_state == ST_WAIT_DONE) || (r_state == ST_WAIT_RELEASE)) &&
                      (r_wdog == 16'(TIMEOUT_CYCLES));

  // Watchdog counter: restarts per shape, runs while waiting on the engine.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wdog    <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wdog_hit;
      if (r_state == ST_START) begin
        r_wdog <= 16'd0;
      end else if ((r_state == ST_WAIT_DONE) || (r_state == ST_WAIT_RELEASE)) begin
        r_wdog <= r_wdog + 16'd1;
      end else begin
        r_wdog <= r_wdog;
      end
    end
  end

  assign shape_timeout = r_timeout;
`else
  assign w_wdog_hit = 1'b0;
`endif

  // Next shape: lowest enabled ID above the current one; clear precedes all.
  always_comb begin
    w_next_found = 1'b0;
    w_next_id    = r_curr_id;
    for (int i = NUM_SHAPES - 1; i >= 0; i--) begin
      if (r_mask[i] && (i != CLEAR_ID) &&
          ((r_curr_id == CLEAR_SEL) || (i > int'(r_curr_id)))) begin
        w_next_found = 1'b1;
        w_next_id    = ID_W'(i);
      end else begin
        w_next_found = w_next_found;
      end
    end
  end

  // Next-state decode of the start/done handshake sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:         w_state_nxt = frame_tick ? ST_START : ST_IDLE;
      ST_START:        w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (w_wdog_hit)      w_state_nxt = ST_NEXT;
        else if (w_done_cur) w_state_nxt = ST_WAIT_RELEASE;
        else                 w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_RELEASE: begin
        if (w_wdog_hit || !w_done_cur) w_state_nxt = ST_NEXT;
        else                           w_state_nxt = ST_WAIT_RELEASE;
      end
      ST_NEXT:         w_state_nxt = w_next_found ? ST_START : ST_IDLE;
      default:         w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus mask, shape ID, start and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_draw_start <= '0;
      r_curr_id    <= CLEAR_SEL;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_overrun <= frame_tick && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (frame_tick) begin
            r_mask    <= shape_enable | (NUM_SHAPES'(1) << CLEAR_ID);
            r_curr_id <= CLEAR_SEL;
            r_busy    <= 1'b1;
          end
        end
        ST_START:        r_draw_start <= NUM_SHAPES'(1) << r_curr_id;
        ST_WAIT_DONE: begin
          if (w_done_cur || w_wdog_hit) r_draw_start <= '0;
        end
        ST_WAIT_RELEASE: r_draw_start <= '0;
        ST_NEXT: begin
          if (w_next_found) r_curr_id <= w_next_id;
          else              r_busy    <= 1'b0;
        end
        default:         r_draw_start <= '0;
      endcase
    end
  end

  assign draw_start    = r_draw_start;
  assign curr_shape_id = r_curr_id;
  assign frame_busy    = r_busy;
  assign frame_overrun = r_overrun;

  shape_port_mux #(
    .NUM_SHAPES (NUM_SHAPES),
    .COORD_W    (COORD_W),
    .COLOUR_W   (COLOUR_W),
    .ID_W       (ID_W)
  ) u_port_mux (
    .i_sel      (r_curr_id),
    .i_plot_en  (w_plot_en),
    .i_plot     (load_plot),
    .i_x        (load_x),
    .i_y        (load_y),
    .i_colour   (load_colour),
    .o_x        (vga_x),
    .o_y        (vga_y),
    .o_colour   (vga_colour),
    .o_plot     (vga_plot)
  );

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Sequences the per-shape drawing engines onto the single shared VGA pixel port, one shape at a time, once per frame. On each frame tick it runs the black-screen clear shape first, then every enabled shape in ascending ID order, using a four-phase `draw_start`/`draw_done` handshake per shape. It muxes the active shape's pixel stream to the VGA adapter and flags frames that overrun the tick period. It sits between the game-state logic, which supplies the enable mask and tick, and the shape modules plus the VGA adapter.

## Interface
Parameters:
- `NUM_SHAPES`, 18: number of shape engines, IDs 0..NUM_SHAPES-1.
- `CLEAR_ID`, 17: ID of the full-screen black clear shape.
- `COORD_W`, 11: x/y width per shape.
- `COLOUR_W`, 3: colour width per shape.
- `TIMEOUT_CYCLES`, 65535: watchdog limit per shape (see Configuration).

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse from the rate divider; requests a new frame.
- `shape_enable` in NUM_SHAPES: shapes to draw this frame. Bit CLEAR_ID is ignored because clear always runs.
- `draw_done` in NUM_SHAPES: per-shape done level.
- `load_plot` in NUM_SHAPES: per-shape pixel-valid.
- `load_x`, `load_y` in NUM_SHAPES*COORD_W: flattened, shape i at bits [i*COORD_W +: COORD_W].
- `load_colour` in NUM_SHAPES*COLOUR_W: flattened, same packing.
- `draw_start` out NUM_SHAPES: one-hot start level. At most one bit is high.
- `vga_x`, `vga_y` out COORD_W; `vga_colour` out COLOUR_W; `vga_plot` out 1: muxed pixel port.
- `curr_shape_id` out $clog2(NUM_SHAPES): shape currently owning the port.
- `frame_busy` out 1: high from frame accept until the last shape finishes.
- `frame_overrun` out 1: one-cycle pulse when a tick is dropped.
- `shape_timeout` out 1: one-cycle pulse when the watchdog aborts a shape. Present only with the macro defined.

## Operation
States: IDLE, START, WAIT_DONE, WAIT_RELEASE, NEXT.

- **IDLE.** On `frame_tick`:
  - Latch `shape_enable` into `frame_mask` and force bit CLEAR_ID set.
  - Set `curr_shape_id` = CLEAR_ID and `frame_busy` = 1.
  - Go to START.
- **START.** Raise `draw_start[curr_shape_id]`, then go to WAIT_DONE.
- **WAIT_DONE.** Hold `draw_start` high. When `draw_done[curr_shape_id]` = 1, drop `draw_start` and go to WAIT_RELEASE.
- **WAIT_RELEASE.** Wait for `draw_done[curr_shape_id]` = 0, then go to NEXT.
- **NEXT.** Pick the lowest set bit of `frame_mask` with ID > the previous ID. CLEAR_ID is excluded after clear and is always visited first regardless of its numeric value.
  - If a bit is found: load it into `curr_shape_id` and go to START.
  - If none remains: clear `frame_busy` and go to IDLE.
- **Mux.** `vga_x`, `vga_y`, `vga_colour` and `vga_plot` select slice `curr_shape_id` combinationally. `vga_plot` is forced to 0 outside START/WAIT_DONE.
- **Dropped ticks.** A `frame_tick` outside IDLE is dropped and pulses `frame_overrun` the next cycle. The in-progress frame continues.
- **Mask stability.** Changes to `shape_enable` mid-frame have no effect until the next accepted tick.
- **Empty mask.** With `shape_enable` all zero, the frame draws only the clear shape.

## Timing
- Reset values: state IDLE, `draw_start` = 0, `curr_shape_id` = CLEAR_ID, `frame_busy` = 0, `frame_overrun` = 0, `shape_timeout` = 0, `frame_mask` = 0.
- Reset mid-frame returns to IDLE next edge and drops all `draw_start` bits.
- Tick accepted at cycle T: `draw_start[CLEAR_ID]` is high from T+2.
- Done seen at edge D: `draw_start` is low after D.
- Release seen at edge R: the next `draw_start` rises at R+2, so the minimum inter-shape gap is 2 cycles.
- Last release at R: `frame_busy` falls after R+1.
- A tick arriving on the same cycle the FSM enters IDLE is accepted.

## Configuration
- `DRAW_SCHEDULER_TIMEOUT_EN` defined:
  - A 16-bit counter clears on START and increments in WAIT_DONE and WAIT_RELEASE.
  - On reaching TIMEOUT_CYCLES it drops `draw_start`, pulses `shape_timeout` and goes to NEXT.
- Undefined: no counter and no `shape_timeout` port. A stuck shape stalls the frame indefinitely.

## Structure
- Shared package `draw_pkg`:
  - state enum
  - `SHAPE_ID_W` constant
  - shape ID constants (square frames 0-6, blocks 7-11, spikes 12-16, clear 17), shared with the game controller.
- One sub-module, `shape_port_mux`: the combinational slice selection of x/y/colour/plot by ID. The FSM, mask and next-ID search stay in `draw_scheduler`.

## Test plan
- Mask 0x00000, tick: `draw_start[17]` only; the stub asserts done 5 cycles after start. Expect `frame_busy` to fall and no other `draw_start` bit to rise.
- Mask 0x00081 (shapes 0 and 7), tick: order is 17, 0, 7. Each start is held until done, with exactly a 2-cycle gap after each release. `vga_x` tracks the active stub's x.
- Second tick during a frame: `frame_overrun` pulses once, the frame completes normally, and no extra frame starts.
- Reset asserted while shape 7 is in WAIT_DONE: the next edge has `draw_start` = 0, state IDLE and `curr_shape_id` = 17. A new tick restarts with clear.
- Stub holds `draw_done` high late (release delayed 10 cycles): no new `draw_start` before release +2.
- With `DRAW_SCHEDULER_TIMEOUT_EN` and TIMEOUT_CYCLES = 20, shape 12 never done: `shape_timeout` pulses 20 cycles after start, then shape 13 starts if enabled.
